// File: rtl/dmem_pkg.sv
// Shared state encoding, bus constants and the alignment rule for data_mem_ctrl.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic WE_STORE = 1'b1;
  localparam logic WE_LOAD  = 1'b0;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  // Halfword masks need an even byte address; a full-word mask needs a word-aligned one.
  function automatic logic misaligned(input logic [1:0] addrLo, input logic [LANES-1:0] mask);
    logic halfBad;
    logic wordBad;
    halfBad = ((mask == 4'b0011) || (mask == 4'b1100)) && addrLo[0];
    wordBad = (mask == 4'b1111) && (addrLo != 2'b00);
    return halfBad || wordBad;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Memory-stage bus between the core (master) and data_mem_ctrl (slave).
// The err line exists only when DMEM_ALIGN_CHECK_EN is defined.
interface data_mem_ctrl_if;

  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        valid;
  logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;

  modport master (output request, we_re, mask, address, store_data,
                  input  load_data, valid, busy, err);
  modport slave  (input  request, we_re, mask, address, store_data,
                  output load_data, valid, busy, err);
`else
  modport master (output request, we_re, mask, address, store_data,
                  input  load_data, valid, busy);
  modport slave  (input  request, we_re, mask, address, store_data,
                  output load_data, valid, busy);
`endif

endinterface

// File: rtl/dmem_byte_ram.sv
// DEPTH x 32 RAM with per-byte write enables and a registered, resettable read port.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  i_we,
  input  logic              i_re,
  input  logic              i_rdZero,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_we[l]) begin
        r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
      end
    end
  end

  // Read register only moves on an explicit read, so stores leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rdZero ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: captures one request, waits WAIT_CYCLES, performs the RAM access, pulses valid.
// Optional DMEM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged on err.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);

  state_t             r_state;
  state_t             w_nextState;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [LANES-1:0]   r_mask;
  logic [ADDR_W-1:0]  r_idx;
  logic [WORD_W-1:0]  r_wdata;
  logic               r_valid;
  logic               w_capture;
  logic               w_doAccess;
  logic               w_nextValid;
  logic               w_bad;
  logic [LANES-1:0]   w_laneWe;
  logic               w_re;
  logic [WORD_W-1:0]  w_rdata;
  logic               w_unused;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] r_addrLo;
  logic       r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addrLo <= 2'b00;
      r_err    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addrLo <= bus.address[1:0];
      end
      r_err <= w_doAccess && w_bad;
    end
  end

  assign w_bad    = misaligned(r_addrLo, r_mask);
  assign bus.err  = r_err;
  assign w_unused = ^bus.address[WORD_W-1:ADDR_W+2];
`else
  assign w_bad    = 1'b0;
  assign w_unused = ^{bus.address[WORD_W-1:ADDR_W+2], bus.address[1:0]};
`endif

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_doAccess  = 1'b0;
    w_nextValid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.request) begin
          w_capture   = 1'b1;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_doAccess  = 1'b1;
          w_nextValid = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= WE_LOAD;
      r_mask  <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_valid <= w_nextValid;
      if (w_capture) begin
        r_cnt   <= 4'(WAIT_CYCLES);
        r_we    <= bus.we_re;
        r_mask  <= bus.mask;
        r_idx   <= bus.address[ADDR_W+1:2];
        r_wdata <= bus.store_data;
      end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign w_laneWe = (w_doAccess && (r_we == WE_STORE) && !w_bad) ? r_mask : '0;
  assign w_re     = w_doAccess && (r_we == WE_LOAD);

  dmem_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_laneWe),
    .i_re     (w_re),
    .i_rdZero (w_bad),
    .i_addr   (r_idx),
    .i_wdata  (r_wdata),
    .o_rdata  (w_rdata)
  );

  assign bus.load_data = w_rdata;
  assign bus.valid     = r_valid;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a word-array model predicts each response, a monitor checks it.
// Define DMEM_ALIGN_CHECK_EN to also exercise the alignment checker and err.
module tb_data_mem_ctrl;

  localparam int WAIT  = 1;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        expQ[$];
  exp_t        monE;
  logic [31:0] modelMem [DEPTH];
  logic [31:0] lastLoad;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(
    .DEPTH       (DEPTH),
    .ADDR_W      (10),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit tbMisaligned(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_ALIGN_CHECK_EN
    case (m)
      4'hF:       return a[1:0] != 2'd0;
      4'h3, 4'hC: return a[0] == 1'b1;
      default:    return 1'b0;
    endcase
`else
    return (a[0] & m[0] & 1'b0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every valid pulse must match the oldest outstanding prediction, on the predicted cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedValid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("loadData", bus.load_data, monE.data);
        checkOutput("validCycle", 32'(cyc), 32'(monE.cyc));
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("err", 32'(bus.err), 32'(monE.err));
`endif
      end
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if (rst === 1'b0 && bus.valid !== 1'b1 && bus.err !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL errWithoutValid actual=%b required=0", bus.err);
    end
`endif
  end

  task automatic waitDone();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && bus.busy === 1'b0) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL timeout actual=pending%0d required=pending0", expQ.size());
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] m,
                               input logic [31:0] a, input logic [31:0] d);
    exp_t       e;
    logic [9:0] idx;
    bit         mis;
    idx   = a[11:2];
    mis   = tbMisaligned(a, m);
    e.err = mis;
    if (we) begin
      if (!mis) begin
        for (int l = 0; l < 4; l++) begin
          if (m[l]) modelMem[idx][8*l +: 8] = d[8*l +: 8];
        end
      end
      e.data = lastLoad;
    end else begin
      e.data   = mis ? 32'h0 : modelMem[idx];
      lastLoad = e.data;
    end
    waitDone();
    bus.request    = 1'b1;
    bus.we_re      = we;
    bus.mask       = m;
    bus.address    = a;
    bus.store_data = d;
    @(posedge clk);
    #1;
    e.cyc = cyc + 1 + WAIT;
    expQ.push_back(e);
    bus.request    = 1'b0;
    bus.we_re      = ~we;
    bus.mask       = 4'($urandom);
    bus.address    = $urandom;
    bus.store_data = $urandom;
    waitDone();
  endtask

  initial begin
    logic [31:0] a;
    rst            = 1'b1;
    bus.request    = 1'b0;
    bus.we_re      = 1'b0;
    bus.mask       = 4'h0;
    bus.address    = 32'h0;
    bus.store_data = 32'h0;
    lastLoad       = 32'h0;

    #17;
    checkOutput("resetValid", 32'(bus.valid), 32'd0);
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetLoadData", bus.load_data, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("resetErr", 32'(bus.err), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'hF, 32'(i * 4), $urandom);
    end

    applyStimulus(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    applyStimulus(1'b0, 4'hF, 32'h40, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h80, 32'h11223344);
    applyStimulus(1'b1, 4'b0010, 32'h80, 32'h0000AA00);
    applyStimulus(1'b0, 4'hF, 32'h80, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h80, 32'hFFFFFFFF);
    applyStimulus(1'b0, 4'hF, 32'h80, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h1000, 32'h5);
    applyStimulus(1'b0, 4'hF, 32'h0, 32'h0);

    // Abort a store while it is still counting wait states.
    waitDone();
    bus.request    = 1'b1;
    bus.we_re      = 1'b1;
    bus.mask       = 4'hF;
    bus.address    = 32'h40;
    bus.store_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.request = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    checkOutput("abortValid", 32'(bus.valid), 32'd0);
    checkOutput("abortLoadData", bus.load_data, 32'h0);
    #1;
    rst      = 1'b0;
    lastLoad = 32'h0;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 4'hF, 32'h40, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(1'b0, 4'hF, 32'h42, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h42, 32'h87654321);
    applyStimulus(1'b0, 4'hF, 32'h40, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      a       = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      applyStimulus(1'($urandom), 4'($urandom), a, $urandom);
    end

    waitDone();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
